// File: rtl/jcu_pkg.sv
// Shared types and constants for the jcu_sequencer control unit.
// Optional build macro: JCU_EARLY_RETIRE_EN (see jcu_sequencer).
package jcu_pkg;

    typedef enum logic [2:0] {
        OP_LD    = 3'b000,
        OP_ST    = 3'b001,
        OP_DATA  = 3'b010,
        OP_JMPR  = 3'b011,
        OP_JMP   = 3'b100,
        OP_JMPIF = 3'b101,
        OP_MISC  = 3'b110,
        OP_IO    = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SHR = 3'b001,
        ALU_SHL = 3'b010,
        ALU_NOT = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_CMP = 3'b111
    } alu_op_e;

    localparam int STEP_W = 3;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

    localparam int FLAG_C = 3;
    localparam int FLAG_A = 2;
    localparam int FLAG_E = 1;
    localparam int FLAG_Z = 0;

    localparam int MISC_CLF  = 0;
    localparam int MISC_HALT = 1;

    typedef struct packed {
        logic       alu;
        logic [2:0] opcode;
        logic       is_halt;
        logic       io_out;
    } ir_fields_t;

    // Final step that carries any strobe for the given instruction.
    function automatic logic [STEP_W-1:0] last_step(input ir_fields_t f);
        logic [STEP_W-1:0] s;
        s = 3'd3;
        if (f.alu) begin
            s = (f.opcode == ALU_CMP) ? 3'd4 : 3'd5;
        end else begin
            case (f.opcode)
                OP_DATA, OP_JMPIF:    s = 3'd5;
                OP_MISC:              s = f.is_halt ? 3'd5 : 3'd3;
                OP_LD, OP_ST, OP_JMP: s = 3'd4;
                OP_IO:                s = f.io_out ? 3'd3 : 3'd4;
                default:              s = 3'd3;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/jcu_stepper.sv
// Phase/step timing generator with IO wait-state hold, HALT freeze and
// run-edge resume; also jumps back to step 0 after the retire step.
module jcu_stepper
    import jcu_pkg::*;
#(
    parameter int NSTEPS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt_instr,
    input  logic [STEP_W-1:0] retire_at,
    input  logic              run,
    output logic [STEP_W-1:0] step,
    output logic [1:0]        phase,
    output logic              halted,
    output logic [STEP_W-1:0] step_next,
    output logic [1:0]        phase_next,
    output logic              halted_next
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);
    localparam logic [STEP_W-1:0] HALT_STEP = 3'd5;

    logic [STEP_W-1:0] step_reg;
    logic [1:0]        phase_reg;
    logic              halted_reg;
    logic              run_prev_reg;

    always_comb begin
        step_next   = step_reg;
        phase_next  = phase_reg;
        halted_next = halted_reg;
        if (halted_reg) begin
            // Only a fresh rising edge of run releases the freeze.
            if (run && !run_prev_reg) begin
                step_next   = '0;
                phase_next  = PH_0;
                halted_next = 1'b0;
            end
        end else if (!stall) begin
            if (phase_reg == PH_3) begin
                phase_next = PH_0;
                step_next  = (step_reg == LAST_STEP || step_reg == retire_at)
                             ? '0 : step_reg + 1'b1;
            end else begin
                phase_next = phase_reg + 2'd1;
                if (halt_instr && step_reg == HALT_STEP && phase_reg == PH_2) begin
                    halted_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_reg     <= '0;
            phase_reg    <= PH_0;
            halted_reg   <= 1'b0;
            run_prev_reg <= 1'b1;
        end else begin
            step_reg     <= step_next;
            phase_reg    <= phase_next;
            halted_reg   <= halted_next;
            run_prev_reg <= run;
        end
    end

    assign step   = step_reg;
    assign phase  = phase_reg;
    assign halted = halted_reg;

endmodule

// File: rtl/jcu_sequencer.sv
// Synchronous CPU control unit: instruction decode and registered strobes.
// Optional macro JCU_EARLY_RETIRE_EN restarts fetch after the last active step.
module jcu_sequencer
    import jcu_pkg::*;
#(
    parameter  int RSEL_W = 2,
    parameter  int NSTEPS = 6,
    localparam int IR_W   = 4 + 2 * RSEL_W,
    localparam int NREGS  = 2 ** RSEL_W
) (
    input  logic              CLK_clk,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_bus,
    input  logic [3:0]        flags_bus,
    input  logic              io_ready,
    input  logic              run,
    output logic [NSTEPS-1:0] stp_bus,
    output logic [1:0]        phase,
    output logic [2:0]        alu_op,
    output logic              alu_ena_ci,
    output logic              flags_s,
    output logic              tmp_s,
    output logic              bus1_bit1,
    output logic              acc_s,
    output logic              acc_e,
    output logic [NREGS-1:0]  reg_s,
    output logic [NREGS-1:0]  reg_e,
    output logic              ram_mar_s,
    output logic              ram_s,
    output logic              ram_e,
    output logic              iar_s,
    output logic              iar_e,
    output logic              ir_s,
    output logic              io_s,
    output logic              io_e,
    output logic              io_io,
    output logic              io_da,
    output logic              halted
);

    localparam int OPW = 2 * RSEL_W;

    // Instruction fields
    logic              ir_alu;
    logic [2:0]        ir_opc;
    logic [RSEL_W-1:0] rega;
    logic [RSEL_W-1:0] regb;
    logic [OPW-1:0]    operand;
    logic [OPW+3:0]    operand_ext;
    logic [3:0]        cond_mask;
    logic              io_io_bit;
    logic              io_da_bit;
    logic              is_clf;
    logic              is_halt;

    assign ir_alu      = ir_bus[IR_W-1];
    assign ir_opc      = ir_bus[IR_W-2 -: 3];
    assign rega        = ir_bus[OPW-1 -: RSEL_W];
    assign regb        = ir_bus[RSEL_W-1:0];
    assign operand     = ir_bus[OPW-1:0];
    assign operand_ext = {operand, 4'b0000};
    assign cond_mask   = operand_ext[OPW+3 -: 4];
    assign io_io_bit   = operand[OPW-1];
    assign io_da_bit   = operand[OPW-2];
    assign is_clf      = (operand == OPW'(MISC_CLF));
    assign is_halt     = (operand == OPW'(MISC_HALT));

    // Stepper interface
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_next;
    logic [1:0]        phase_next;
    logic              halted_next;
    logic [STEP_W-1:0] retire_at;
    logic [STEP_W-1:0] io_step;
    logic              io_instr;
    logic              stall;
    logic              halt_instr;

    assign io_instr   = !ir_alu && (ir_opc == OP_IO);
    assign io_step    = io_io_bit ? 3'd3 : 3'd4;
    assign stall      = io_instr && (step == io_step) && (phase == PH_1) && !io_ready;
    assign halt_instr = !ir_alu && (ir_opc == OP_MISC) && is_halt;

`ifdef JCU_EARLY_RETIRE_EN
    ir_fields_t fields;
    assign fields    = {ir_alu, ir_opc, is_halt, io_io_bit};
    assign retire_at = last_step(fields);
`else
    assign retire_at = STEP_W'(NSTEPS - 1);
`endif

    jcu_stepper #(
        .NSTEPS (NSTEPS)
    ) u_stepper (
        .clk         (CLK_clk),
        .rst         (reset),
        .stall       (stall),
        .halt_instr  (halt_instr),
        .retire_at   (retire_at),
        .run         (run),
        .step        (step),
        .phase       (phase),
        .halted      (halted),
        .step_next   (step_next),
        .phase_next  (phase_next),
        .halted_next (halted_next)
    );

    // Conditional-jump decision: flags taken during s5 phase 0, held after.
    logic take_now;
    logic jmp_take;
    logic jmp_take_reg;

    assign take_now = (cond_mask[FLAG_C] & flags_bus[FLAG_C])
                    | (cond_mask[FLAG_A] & flags_bus[FLAG_A])
                    | (cond_mask[FLAG_E] & flags_bus[FLAG_E])
                    | (cond_mask[FLAG_Z] & flags_bus[FLAG_Z]);
    assign jmp_take = (step == 3'd5 && phase == PH_0) ? take_now : jmp_take_reg;

    // Per-step intent, decoded for the state being entered
    logic e_bus1, e_iar, e_ram, e_acc, e_alu, e_rega, e_regb, e_io;
    logic s_mar, s_acc, s_ir, s_iar, s_tmp, s_flags, s_ram, s_regb, s_io;
    logic io_act;

    always_comb begin
        e_bus1 = 1'b0; e_iar = 1'b0; e_ram = 1'b0; e_acc = 1'b0;
        e_alu = 1'b0; e_rega = 1'b0; e_regb = 1'b0; e_io = 1'b0;
        s_mar = 1'b0; s_acc = 1'b0; s_ir = 1'b0; s_iar = 1'b0; s_tmp = 1'b0;
        s_flags = 1'b0; s_ram = 1'b0; s_regb = 1'b0; s_io = 1'b0;
        io_act = 1'b0;
        case (step_next)
            3'd0: begin e_bus1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
            3'd1: begin e_ram = 1'b1; s_ir = 1'b1; end
            3'd2: begin e_acc = 1'b1; s_iar = 1'b1; end
            3'd3: begin
                if (ir_alu) begin
                    e_regb = 1'b1; s_tmp = 1'b1;
                end else begin
                    case (ir_opc)
                        OP_LD, OP_ST: begin e_rega = 1'b1; s_mar = 1'b1; end
                        OP_DATA, OP_JMPIF: begin
                            e_bus1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1;
                        end
                        OP_JMPR: begin e_regb = 1'b1; s_iar = 1'b1; end
                        OP_JMP:  begin e_iar = 1'b1; s_mar = 1'b1; end
                        OP_MISC: begin e_bus1 = is_clf; s_flags = is_clf; end
                        OP_IO: begin
                            e_regb = io_io_bit; s_io = io_io_bit; io_act = io_io_bit;
                        end
                        default: ;
                    endcase
                end
            end
            3'd4: begin
                if (ir_alu) begin
                    e_rega = 1'b1; e_alu = 1'b1; s_acc = 1'b1; s_flags = 1'b1;
                end else begin
                    case (ir_opc)
                        OP_LD, OP_DATA: begin e_ram = 1'b1; s_regb = 1'b1; end
                        OP_ST:    begin e_regb = 1'b1; s_ram = 1'b1; end
                        OP_JMP:   begin e_ram = 1'b1; s_iar = 1'b1; end
                        OP_JMPIF: begin e_acc = 1'b1; s_iar = 1'b1; end
                        OP_IO: begin
                            e_io = !io_io_bit; s_regb = !io_io_bit; io_act = !io_io_bit;
                        end
                        default: ;
                    endcase
                end
            end
            3'd5: begin
                if (ir_alu) begin
                    e_acc  = (ir_opc != ALU_CMP);
                    s_regb = (ir_opc != ALU_CMP);
                end else if (ir_opc == OP_DATA) begin
                    e_acc = 1'b1; s_iar = 1'b1;
                end else if (ir_opc == OP_JMPIF) begin
                    e_ram = jmp_take; s_iar = jmp_take;
                end
            end
            default: ;
        endcase
    end

    logic en_ok;
    logic set_ok;
    assign en_ok  = (phase_next != PH_0) && !halted_next;
    assign set_ok = (phase_next == PH_2) && !halted_next;

    logic [NREGS-1:0]  reg_e_next;
    logic [NREGS-1:0]  reg_s_next;
    logic [NSTEPS-1:0] stp_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            assign reg_e_next[gi] = en_ok & ((e_rega & (rega == RSEL_W'(gi)))
                                           | (e_regb & (regb == RSEL_W'(gi))));
            assign reg_s_next[gi] = set_ok & s_regb & (regb == RSEL_W'(gi));
        end
        for (gi = 0; gi < NSTEPS; gi++) begin : g_stp
            assign stp_next[gi] = (step_next == STEP_W'(gi));
        end
    endgenerate

    always_ff @(posedge CLK_clk or posedge reset) begin
        if (reset) begin
            stp_bus      <= NSTEPS'(1);
            jmp_take_reg <= 1'b0;
            alu_op       <= 3'd0;
            alu_ena_ci   <= 1'b0;
            flags_s      <= 1'b0;
            tmp_s        <= 1'b0;
            bus1_bit1    <= 1'b0;
            acc_s        <= 1'b0;
            acc_e        <= 1'b0;
            reg_s        <= '0;
            reg_e        <= '0;
            ram_mar_s    <= 1'b0;
            ram_s        <= 1'b0;
            ram_e        <= 1'b0;
            iar_s        <= 1'b0;
            iar_e        <= 1'b0;
            ir_s         <= 1'b0;
            io_s         <= 1'b0;
            io_e         <= 1'b0;
            io_io        <= 1'b0;
            io_da        <= 1'b0;
        end else begin
            stp_bus      <= stp_next;
            jmp_take_reg <= jmp_take;
            alu_op       <= (en_ok && e_alu) ? ir_opc : 3'd0;
            alu_ena_ci   <= en_ok & e_alu;
            flags_s      <= set_ok & s_flags;
            tmp_s        <= set_ok & s_tmp;
            bus1_bit1    <= en_ok & e_bus1;
            acc_s        <= set_ok & s_acc;
            acc_e        <= en_ok & e_acc;
            reg_s        <= reg_s_next;
            reg_e        <= reg_e_next;
            ram_mar_s    <= set_ok & s_mar;
            ram_s        <= set_ok & s_ram;
            ram_e        <= en_ok & e_ram;
            iar_s        <= set_ok & s_iar;
            iar_e        <= en_ok & e_iar;
            ir_s         <= set_ok & s_ir;
            io_s         <= set_ok & s_io;
            io_e         <= en_ok & e_io;
            io_io        <= en_ok & io_act & io_io_bit;
            io_da        <= en_ok & io_act & io_da_bit;
        end
    end

endmodule

// File: tb/tb_jcu_sequencer.sv
// Directed scoreboard bench for jcu_sequencer (RSEL_W=2, NSTEPS=6).
module tb_jcu_sequencer;

    logic       CLK_clk = 1'b0;
    logic       reset;
    logic [7:0] ir_bus;
    logic [3:0] flags_bus;
    logic       io_ready;
    logic       run;
    logic [5:0] stp_bus;
    logic [1:0] phase;
    logic [2:0] alu_op;
    logic       alu_ena_ci, flags_s, tmp_s, bus1_bit1, acc_s, acc_e;
    logic [3:0] reg_s, reg_e;
    logic       ram_mar_s, ram_s, ram_e, iar_s, iar_e, ir_s, io_s, io_e, io_io, io_da;
    logic       halted;

    jcu_sequencer #(.RSEL_W(2), .NSTEPS(6)) dut (
        .CLK_clk(CLK_clk), .reset(reset), .ir_bus(ir_bus), .flags_bus(flags_bus),
        .io_ready(io_ready), .run(run), .stp_bus(stp_bus), .phase(phase),
        .alu_op(alu_op), .alu_ena_ci(alu_ena_ci), .flags_s(flags_s), .tmp_s(tmp_s),
        .bus1_bit1(bus1_bit1), .acc_s(acc_s), .acc_e(acc_e), .reg_s(reg_s),
        .reg_e(reg_e), .ram_mar_s(ram_mar_s), .ram_s(ram_s), .ram_e(ram_e),
        .iar_s(iar_s), .iar_e(iar_e), .ir_s(ir_s), .io_s(io_s), .io_e(io_e),
        .io_io(io_io), .io_da(io_da), .halted(halted)
    );

    always #5 CLK_clk = ~CLK_clk;

    int cyc_cnt = 0;
    always @(posedge CLK_clk) cyc_cnt <= cyc_cnt + 1;

    // Bit positions inside the packed strobe word
    localparam int B_IO_E = 2, B_IAR_E = 5, B_IAR_S = 6, B_RAM_E = 7, B_MAR_S = 9;
    localparam int B_REG_S = 14, B_ACC_S = 19, B_BUS1 = 20, B_FLAGS_S = 22;
    localparam logic [31:0] V_S0P1 = (32'd1 << B_BUS1) | (32'd1 << B_IAR_E);
    localparam logic [31:0] V_S0P2 = V_S0P1 | (32'd1 << B_MAR_S) | (32'd1 << B_ACC_S);

`ifdef JCU_EARLY_RETIRE_EN
    localparam int LEN_CMP = 20, LEN_JMPR = 16;
`else
    localparam int LEN_CMP = 24, LEN_JMPR = 24;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] strobes();
        return {5'd0, alu_op, alu_ena_ci, flags_s, tmp_s, bus1_bit1, acc_s, acc_e,
                reg_s, reg_e, ram_mar_s, ram_s, ram_e, iar_s, iar_e, ir_s, io_s,
                io_e, io_io, io_da};
    endfunction

    function automatic int cur_step();
        int r = -1;
        for (int i = 0; i < 6; i++) if (stp_bus[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] sp();
        return 32'(cur_step() * 16 + int'(phase));
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(negedge CLK_clk);
    endtask

    task automatic goto_sp(input int s, input int p, input string tag);
        int n = 0;
        while (!(cur_step() == s && int'(phase) == p) && n < 300) begin
            cyc();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=%0h expected=%0h", tag, sp(), s * 16 + p);
        end
    endtask

    int t0, n, pulses;

    initial begin
        reset = 1'b1; ir_bus = 8'h00; flags_bus = 4'h0; io_ready = 1'b1; run = 1'b1;
        repeat (2) cyc();

        // Reset state
        push("rst_stp_bus", 32'h1); push("rst_phase", 32'h0);
        push("rst_strobes", 32'h0); push("rst_halted", 32'h0);
        pop_check(32'(stp_bus)); pop_check(32'(phase));
        pop_check(strobes()); pop_check(32'(halted));
        reset = 1'b0;

        // ADD R1,R2
        ir_bus = 8'b1000_0110; t0 = cyc_cnt;
        push("add_s0p2_vec", V_S0P2);
        push("add_s4p2_acc_s", 32'h1); push("add_s4p2_flags_s", 32'h1);
        push("add_s4p2_alu_op", 32'h0); push("add_s4p2_reg_e", 32'h2);
        push("add_s5p2_reg_s", 32'h4); push("add_s5p2_acc_e", 32'h1);
        push("add_len", 32'd24);
        goto_sp(0, 2, "add_s0p2"); pop_check(strobes());
        goto_sp(4, 2, "add_s4p2");
        pop_check(32'(acc_s)); pop_check(32'(flags_s));
        pop_check(32'(alu_op)); pop_check(32'(reg_e));
        goto_sp(5, 2, "add_s5p2");
        pop_check(32'(reg_s)); pop_check(32'(acc_e));
        goto_sp(0, 0, "add_end"); pop_check(32'(cyc_cnt - t0));

        // AND R3,R0
        ir_bus = 8'b1100_1100;
        push("and_s4p1_alu_op", 32'h4); push("and_s4p1_ci", 32'h1);
        push("and_s4p1_reg_e", 32'h8); push("and_s5p2_reg_s", 32'h1);
        goto_sp(4, 1, "and_s4p1");
        pop_check(32'(alu_op)); pop_check(32'(alu_ena_ci)); pop_check(32'(reg_e));
        goto_sp(5, 2, "and_s5p2"); pop_check(32'(reg_s));
        goto_sp(0, 0, "and_end");

        // CMP: no step-5 write-back
        ir_bus = 8'b1111_0110; t0 = cyc_cnt;
        push("cmp_s4p2_flags_s", 32'h1);
`ifndef JCU_EARLY_RETIRE_EN
        push("cmp_s5p2_vec", 32'h0);
`endif
        push("cmp_len", 32'(LEN_CMP));
        goto_sp(4, 2, "cmp_s4p2"); pop_check(32'(flags_s));
`ifndef JCU_EARLY_RETIRE_EN
        goto_sp(5, 2, "cmp_s5p2"); pop_check(strobes());
`endif
        cyc(); goto_sp(0, 0, "cmp_end"); pop_check(32'(cyc_cnt - t0));

        // Asynchronous reset in the middle of an instruction
        ir_bus = 8'b1000_0110;
        goto_sp(4, 2, "rstmid_s4p2");
        reset = 1'b1; #1;
        push("rstmid_stp_bus", 32'h1); push("rstmid_phase", 32'h0); push("rstmid_vec", 32'h0);
        pop_check(32'(stp_bus)); pop_check(32'(phase)); pop_check(strobes());
        cyc(); reset = 1'b0; cyc();
        push("rstmid_s0p1_vec", V_S0P1); pop_check(strobes());
        goto_sp(0, 0, "rstmid_end");

        // JMPIF C taken; flags drop after the s5 phase-0 sample
        ir_bus = 8'b0101_1000; flags_bus = 4'b1000;
        push("jmpif_s5p1_ram_e", 32'h1); push("jmpif_s5_iar_pulses", 32'h1);
        goto_sp(5, 1, "jmpif_s5p1"); pop_check(32'(ram_e));
        flags_bus = 4'b0000; pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (iar_s) pulses++;
            cyc();
        end
        pop_check(32'(pulses));

        // JMPIF C not taken
        push("jmpif_nt_s5p1", 32'h0); push("jmpif_nt_s5p2", 32'h0); push("jmpif_nt_s5p3", 32'h0);
        goto_sp(5, 1, "jmpif_nt_s5p1");
        for (int k = 0; k < 3; k++) begin
            pop_check(strobes());
            cyc();
        end
        goto_sp(0, 0, "jmpif_end");

        // IN R3 with a 10-cycle wait state
        ir_bus = 8'b0111_0011; io_ready = 1'b0;
        goto_sp(4, 1, "in_s4p1");
        for (int k = 0; k < 10; k++) begin
            push("in_hold_sp", 32'h41); push("in_hold_vec", 32'd1 << B_IO_E);
            pop_check(sp()); pop_check(strobes());
            if (k == 9) io_ready = 1'b1;
            cyc();
        end
        push("in_s4p2_vec", (32'd1 << B_IO_E) | (32'd1 << (B_REG_S + 3)));
        push("in_reg_s_pulses", 32'h1);
        pop_check(strobes());
        pulses = 0; n = 0;
        while (!(cur_step() == 0 && phase == 2'd0) && n < 40) begin
            if (reg_s == 4'b1000) pulses++;
            cyc(); n++;
        end
        pop_check(32'(pulses));

        // HALT with run held high, then a run edge
        ir_bus = 8'b0110_0001; n = 0;
        while (!halted && n < 60) begin
            cyc(); n++;
        end
        push("halt_entry_sp", 32'h53); pop_check(sp());
        for (int k = 0; k < 5; k++) begin
            push("halt_hold", 32'h1); push("halt_hold_sp", 32'h53); push("halt_hold_vec", 32'h0);
            pop_check(32'(halted)); pop_check(sp()); pop_check(strobes());
            cyc();
        end
        run = 1'b0; cyc();
        push("halt_run_low", 32'h1); pop_check(32'(halted));
        run = 1'b1; ir_bus = 8'b0011_0010; cyc();
        push("resume_halted", 32'h0); push("resume_sp", 32'h00);
        pop_check(32'(halted)); pop_check(sp());
        cyc();
        push("resume_s0p1_vec", V_S0P1); pop_check(strobes());

        // JMPR R2
        push("jmpr_s3p2_iar_s", 32'h1); push("jmpr_s3p2_reg_e", 32'h4);
        push("jmpr_len", 32'(LEN_JMPR));
        goto_sp(3, 2, "jmpr_s3p2"); pop_check(32'(iar_s)); pop_check(32'(reg_e));
        goto_sp(0, 0, "jmpr_start"); t0 = cyc_cnt;
        cyc(); goto_sp(0, 0, "jmpr_end"); pop_check(32'(cyc_cnt - t0));

        // CLF
        ir_bus = 8'b0110_0000;
        push("clf_s3p2_vec", (32'd1 << B_BUS1) | (32'd1 << B_FLAGS_S));
        goto_sp(3, 2, "clf_s3p2"); pop_check(strobes());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
